// File: rtl/ospfb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// ospfb_capture_ctrl : skips warm-up frames, then forwards N OSPFB frames to AXIS
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ospfb_capture_ctrl #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 64,
  parameter int FRAME_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [FRAME_W-1:0]   num_frames,
  input  logic [FRAME_W-1:0]   skip_frames,
  output logic                 en_out,
  input  logic [2*WIDTH-1:0]   s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic [FRAME_W-1:0]   frame_cnt,
  output logic                 overflow
);

  localparam int              CNT_W       = $clog2(FFT_LEN);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FFT_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SKIP    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   sample_q, sample_d;
  logic [FRAME_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0] num_q, num_d;
  logic [FRAME_W-1:0] skip_num_q, skip_num_d;
  logic               overflow_q, overflow_d;

  logic pass_through;
  logic last_beat;
  logic handshake;

  assign pass_through = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign last_beat    = (sample_q == LAST_SAMPLE);
  assign handshake    = s_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      skip_cnt_q  <= '0;
      frame_cnt_q <= '0;
      num_q       <= '0;
      skip_num_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      skip_cnt_q  <= skip_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      num_q       <= num_d;
      skip_num_q  <= skip_num_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    skip_cnt_d  = skip_cnt_q;
    frame_cnt_d = frame_cnt_q;
    num_d       = num_q;
    skip_num_d  = skip_num_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d       = num_frames;
          skip_num_d  = skip_frames;
          frame_cnt_d = '0;
          overflow_d  = 1'b0;
          sample_d    = '0;
          skip_cnt_d  = '0;
          state_d     = (skip_frames != '0) ? S_SKIP : S_CAPTURE;
        end
      end
      S_SKIP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (s_axis_tvalid) begin
          // sample counter wraps naturally because FFT_LEN is a power of two
          sample_d = sample_q + 1'b1;
          if (last_beat) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
            if (skip_cnt_q + 1'b1 == skip_num_q) state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE, S_DRAIN: begin
        if (s_axis_tvalid && !m_axis_tready) overflow_d = 1'b1;
        if (handshake) begin
          sample_d = sample_q + 1'b1;
          if (last_beat && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        end
        // an abort landing on a frame boundary needs no drain: the frame is already whole
        if (handshake && last_beat &&
            ((state_q == S_DRAIN) || abort || (num_q != '0 && frame_cnt_d == num_q))) begin
          state_d = S_DONE;
        end else if (state_q == S_CAPTURE && abort) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_out        = (state_q == S_SKIP) || pass_through;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    s_axis_tready = (state_q == S_SKIP) || (pass_through && m_axis_tready);
    m_axis_tvalid = pass_through && s_axis_tvalid;
    m_axis_tdata  = pass_through ? s_axis_tdata : '0;
    m_axis_tlast  = pass_through && last_beat;
    frame_cnt     = frame_cnt_q;
    overflow      = overflow_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ospfb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ospfb_capture_ctrl : randomized bench with a beat-count reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ospfb_capture_ctrl;

  localparam int WIDTH   = 8;
  localparam int FFT_LEN = 8;
  localparam int FRAME_W = 4;
  localparam int DW      = 2 * WIDTH;
  localparam int FMAX    = (1 << FRAME_W) - 1;
  localparam int INF     = 1 << 30;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [FRAME_W-1:0] num_frames = '0;
  logic [FRAME_W-1:0] skip_frames = '0;
  logic               en_out;
  logic [DW-1:0]      s_axis_tdata = '0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b0;
  logic               m_axis_tlast;
  logic               busy;
  logic               done;
  logic [FRAME_W-1:0] frame_cnt;
  logic               overflow;

  always #5 clk = ~clk;

  ospfb_capture_ctrl #(.WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAME_W(FRAME_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_frames(num_frames), .skip_frames(skip_frames), .en_out(en_out),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a capture is described by beats accepted since start,
  // forwarded beats, and a frame target that abort can lower.
  bit md_active = 0, md_done = 0, md_ovf = 0;
  int md_beats = 0, md_fwd = 0, md_skip = 0, md_target = 0, md_fcnt = 0;
  bit exp_s_ready = 0;
  bit last_acc = 0;
  logic [DW-1:0] seq = '0;
  int valid_pct = 100, ready_pct = 100;
  bit ready_toggle = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit skipping();
    return md_beats < md_skip * FFT_LEN;
  endfunction

  task automatic check_outputs();
    bit cap;
    cap = md_active && !skipping();
    exp_s_ready = md_active && (skipping() || m_axis_tready);
    check_val("busy", busy, md_active || md_done);
    check_val("en_out", en_out, md_active);
    check_val("done", done, md_done);
    check_val("s_tready", s_axis_tready, exp_s_ready);
    check_val("m_tvalid", m_axis_tvalid, cap && s_axis_tvalid);
    check_val("m_tlast", m_axis_tlast, cap && (md_fwd % FFT_LEN == FFT_LEN - 1));
    if (cap && s_axis_tvalid) check_val("m_tdata", m_axis_tdata, s_axis_tdata);
    check_val("frame_cnt", frame_cnt, md_fcnt);
    check_val("overflow", overflow, md_ovf);
  endtask

  task automatic model_step();
    last_acc = s_axis_tvalid && exp_s_ready;
    if (last_acc) seq = seq + 1'b1;
    if (!rst) begin
      md_active = 0; md_done = 0; md_ovf = 0;
      md_beats = 0; md_fwd = 0; md_skip = 0; md_target = 0; md_fcnt = 0;
    end else if (md_done) begin
      md_done = 0;
    end else if (!md_active) begin
      if (start) begin
        md_active = 1; md_beats = 0; md_fwd = 0; md_fcnt = 0; md_ovf = 0;
        md_skip   = int'(skip_frames);
        md_target = (num_frames == 0) ? INF : int'(num_frames);
      end
    end else if (skipping()) begin
      if (abort) md_active = 0;
      else if (s_axis_tvalid) md_beats++;
    end else begin
      if (s_axis_tvalid && !m_axis_tready) md_ovf = 1;
      if (abort && (md_fwd / FFT_LEN + 1 < md_target)) md_target = md_fwd / FFT_LEN + 1;
      if (s_axis_tvalid && m_axis_tready) begin
        md_beats++;
        md_fwd++;
        if (md_fwd % FFT_LEN == 0) begin
          md_fcnt = (md_fwd / FFT_LEN > FMAX) ? FMAX : md_fwd / FFT_LEN;
          if (md_fwd / FFT_LEN >= md_target) begin
            md_active = 0;
            md_done   = 1;
          end
        end
      end
    end
  endtask

  task automatic tick(input logic st, input logic ab, input logic rs);
    start = st;
    abort = ab;
    rst   = rs;
    // a stalled beat is held; otherwise the source offers the next sample
    if (!(s_axis_tvalid && !last_acc)) begin
      s_axis_tvalid = ($urandom_range(99) < valid_pct);
      s_axis_tdata  = seq;
    end
    m_axis_tready = ready_toggle ? ~m_axis_tready : ($urandom_range(99) < ready_pct);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_to_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!(md_active || md_done)) break;
      tick(1'b0, 1'b0, 1'b1);
    end
    check_val("idle_reached", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b1);

    // skip 2, capture 3, continuous flow
    valid_pct = 100; ready_pct = 100; ready_toggle = 0;
    skip_frames = 4'd2; num_frames = 4'd3;
    tick(1'b1, 1'b0, 1'b1);
    run_to_idle(100);
    check_val("t1_frame_cnt", frame_cnt, 3);
    check_val("t1_overflow", overflow, 0);

    // ready toggling, one frame, stalls expected
    skip_frames = 4'd0; num_frames = 4'd1; ready_toggle = 1;
    tick(1'b1, 1'b0, 1'b1);
    run_to_idle(100);
    check_val("t2_frame_cnt", frame_cnt, 1);
    check_val("t2_overflow", overflow, 1);
    ready_toggle = 0;

    // continuous capture aborted at sample 3 of frame 2
    skip_frames = 4'd0; num_frames = 4'd0;
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100 && md_active; i++)
      tick(1'b0, logic'(md_active && !skipping() && md_fwd == 2 * FFT_LEN + 3), 1'b1);
    run_to_idle(50);
    check_val("t3_frame_cnt", frame_cnt, 3);

    // abort during skip
    skip_frames = 4'd3; num_frames = 4'd2;
    tick(1'b1, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check_val("t4_busy", busy, 0);
    check_val("t4_en_out", en_out, 0);
    repeat (2) tick(1'b0, 1'b0, 1'b1);

    // reset mid-capture, then a clean capture
    skip_frames = 4'd0; num_frames = 4'd2;
    tick(1'b1, 1'b0, 1'b1);
    repeat (12) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check_val("t5_rst_frame_cnt", frame_cnt, 0);
    check_val("t5_rst_busy", busy, 0);
    tick(1'b1, 1'b0, 1'b1);
    run_to_idle(100);
    check_val("t5_frame_cnt", frame_cnt, 2);

    // start while busy is ignored; start with abort in idle starts
    skip_frames = 4'd1; num_frames = 4'd1;
    tick(1'b1, 1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    run_to_idle(100);
    tick(1'b1, 1'b1, 1'b1);
    check_val("t6_start_abort_busy", busy, 1);
    run_to_idle(100);
    check_val("t6_frame_cnt", frame_cnt, 1);

    // frame counter saturation in continuous mode
    skip_frames = 4'd0; num_frames = 4'd0;
    tick(1'b1, 1'b0, 1'b1);
    repeat (17 * FFT_LEN + 2) tick(1'b0, 1'b0, 1'b1);
    check_val("t7_saturated", frame_cnt, FMAX);
    tick(1'b0, 1'b1, 1'b1);
    run_to_idle(50);
    check_val("t7_saturated_hold", frame_cnt, FMAX);

    // randomized captures
    for (int it = 0; it < 120; it++) begin
      valid_pct = ($urandom_range(1) == 0) ? 100 : int'($urandom_range(40, 100));
      ready_pct = ($urandom_range(1) == 0) ? 100 : int'($urandom_range(40, 100));
      skip_frames = FRAME_W'($urandom_range(0, 3));
      num_frames  = FRAME_W'($urandom_range(0, 4));
      tick(1'b1, 1'b0, 1'b1);
      num_frames  = FRAME_W'($urandom);
      skip_frames = FRAME_W'($urandom);
      for (int c = 0; c < 150 && (md_active || md_done); c++)
        tick(logic'($urandom_range(19) == 0), logic'($urandom_range(59) == 0),
             logic'($urandom_range(499) != 0));
      if (md_active) tick(1'b0, 1'b1, 1'b1);
      run_to_idle(300);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
